// File: rtl/layer_compositor_if.sv
// Bus bundle for layer_compositor: pixel/layer inputs, enable-update handshake,
// expanded colour outputs and collision report. slave = compositor side.
interface layer_compositor_if #(
    parameter int NUM_LAYERS = 4
) ();
    logic                      pix_valid;
    logic                      frame_start;
    logic [NUM_LAYERS-1:0]     layer_draw;
    logic [8*NUM_LAYERS-1:0]   layer_rgb;
    logic [7:0]                background_rgb;
    logic                      cfg_valid;
    logic [NUM_LAYERS-1:0]     cfg_layer_en;
    logic                      cfg_ready;
    logic [7:0]                m_mVGA_R;
    logic [7:0]                m_mVGA_G;
    logic [7:0]                m_mVGA_B;
    logic                      out_valid;
    logic [NUM_LAYERS-1:0]     collision_mask;
    logic                      collision_valid;

    modport master (
        output pix_valid, frame_start, layer_draw, layer_rgb, background_rgb,
               cfg_valid, cfg_layer_en,
        input  cfg_ready, m_mVGA_R, m_mVGA_G, m_mVGA_B, out_valid,
               collision_mask, collision_valid
    );

    modport slave (
        input  pix_valid, frame_start, layer_draw, layer_rgb, background_rgb,
               cfg_valid, cfg_layer_en,
        output cfg_ready, m_mVGA_R, m_mVGA_G, m_mVGA_B, out_valid,
               collision_mask, collision_valid
    );
endinterface

// File: rtl/layer_compositor.sv
// Priority layer compositor: highest opaque object layer over background, RGB332 -> 8-bit RGB,
// frame-synchronous layer enables; per-frame collision report when LAYER_COMPOSITOR_COLLISION_EN is defined.
module layer_compositor #(
    parameter int         NUM_LAYERS  = 4,
    parameter logic [7:0] TRANSPARENT = 8'hFF
) (
    input logic               CLK,
    input logic               RESETn,
    layer_compositor_if.slave bus
);
    logic [NUM_LAYERS-1:0] active_en;
    logic [NUM_LAYERS-1:0] pending_en;
    logic                  pending;
    logic                  cfg_fire;
    logic [NUM_LAYERS-1:0] opaque;
    logic [7:0]            sel_rgb;

    logic                  s1_valid;
    logic [7:0]            s1_rgb;
    logic                  s2_valid;
    logic [7:0]            s2_r;
    logic [7:0]            s2_g;
    logic [7:0]            s2_b;

    always_comb begin
        opaque = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            opaque[i] = bus.layer_draw[i] & active_en[i] &
                        (bus.layer_rgb[8*i +: 8] != TRANSPARENT);
        end
    end

    // Ascending scan: a later (higher-priority) opaque layer overrides earlier ones.
    always_comb begin
        sel_rgb = bus.background_rgb;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (opaque[i]) sel_rgb = bus.layer_rgb[8*i +: 8];
        end
    end

    // Enable handshake: a transfer happens on cfg_valid & cfg_ready; cfg_ready is low while an
    // update is pending, and a requester seeing it low must hold cfg_valid and cfg_layer_en.
    // The pending mask takes effect at the next frame_start strictly after the transfer cycle.
    assign cfg_fire      = bus.cfg_valid & ~pending;
    assign bus.cfg_ready = ~pending;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            active_en  <= '1;
            pending_en <= '1;
            pending    <= 1'b0;
        end else begin
            if (bus.frame_start && pending) begin
                active_en <= pending_en;
                pending   <= 1'b0;
            end
            if (cfg_fire) begin
                pending_en <= bus.cfg_layer_en;
                pending    <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            s1_valid <= 1'b0;
            s1_rgb   <= '0;
            s2_valid <= 1'b0;
            s2_r     <= '0;
            s2_g     <= '0;
            s2_b     <= '0;
        end else begin
            s1_valid <= bus.pix_valid;
            s1_rgb   <= sel_rgb;
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_r <= {s1_rgb[7:5], 5'b0};
                s2_g <= {s1_rgb[4:2], 5'b0};
                s2_b <= {s1_rgb[1:0], 6'b0};
            end else begin
                s2_r <= '0;
                s2_g <= '0;
                s2_b <= '0;
            end
        end
    end

    assign bus.m_mVGA_R  = s2_r;
    assign bus.m_mVGA_G  = s2_g;
    assign bus.m_mVGA_B  = s2_b;
    assign bus.out_valid = s2_valid;

`ifdef LAYER_COMPOSITOR_COLLISION_EN
    logic                  multi;
    logic                  seen;
    logic [NUM_LAYERS-1:0] coll;
    logic [NUM_LAYERS-1:0] coll_q;
    logic [NUM_LAYERS-1:0] acc;
    logic [NUM_LAYERS-1:0] cmask_q;
    logic                  cvalid_q;

    // A layer collides when it is opaque and at least one other layer is opaque too.
    always_comb begin
        multi = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (opaque[i] && seen) multi = 1'b1;
            seen = seen | opaque[i];
        end
        coll = (multi && bus.pix_valid) ? opaque : '0;
    end

    // coll_q captured at the frame_start edge belongs to the new frame, so acc restarts from 0.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            coll_q   <= '0;
            acc      <= '0;
            cmask_q  <= '0;
            cvalid_q <= 1'b0;
        end else begin
            coll_q <= coll;
            if (bus.frame_start) begin
                cmask_q  <= acc | coll_q;
                acc      <= '0;
                cvalid_q <= 1'b1;
            end else begin
                acc      <= acc | coll_q;
                cvalid_q <= 1'b0;
            end
        end
    end

    assign bus.collision_mask  = cmask_q;
    assign bus.collision_valid = cvalid_q;
`else
    assign bus.collision_mask  = '0;
    assign bus.collision_valid = 1'b0;
`endif
endmodule

// File: tb/tb_layer_compositor.sv
// Randomised bench for layer_compositor against a per-pixel reference model with a 2-deep
// expected-output queue; collision expectations follow LAYER_COMPOSITOR_COLLISION_EN.
module tb_layer_compositor;
    localparam int N = 4;

    logic CLK    = 1'b0;
    logic RESETn = 1'b1;

    always #5 CLK = ~CLK;

    layer_compositor_if #(.NUM_LAYERS(N)) bus ();

    layer_compositor #(.NUM_LAYERS(N), .TRANSPARENT(8'hFF)) dut (
        .CLK   (CLK),
        .RESETn(RESETn),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errs   = 0;

    logic [24:0]  exp_q[$];        // {valid, R, G, B}
    logic [N-1:0] m_active_en;
    logic [N-1:0] m_pending_en;
    logic         m_pending;
    logic [N-1:0] m_acc;
    logic [N-1:0] exp_cmask;
    logic         exp_cvalid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [24:0] expand(input logic valid, input logic [7:0] c);
        if (!valid) return 25'd0;
        return {1'b1, c[7:5], 5'b0, c[4:2], 5'b0, c[1:0], 6'b0};
    endfunction

    task automatic drive_idle();
        bus.pix_valid      = 1'b0;
        bus.frame_start    = 1'b0;
        bus.layer_draw     = '0;
        bus.layer_rgb      = '0;
        bus.background_rgb = '0;
        bus.cfg_valid      = 1'b0;
        bus.cfg_layer_en   = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_r"},      bus.m_mVGA_R, 0);
        check_eq({tag, "_g"},      bus.m_mVGA_G, 0);
        check_eq({tag, "_b"},      bus.m_mVGA_B, 0);
        check_eq({tag, "_valid"},  bus.out_valid, 0);
        check_eq({tag, "_cmask"},  bus.collision_mask, 0);
        check_eq({tag, "_cvalid"}, bus.collision_valid, 0);
        check_eq({tag, "_ready"},  bus.cfg_ready, 1);
    endtask

    task automatic apply_reset();
        drive_idle();
        RESETn = 1'b0;
        #1;
        check_reset_outputs("in_reset");
        @(negedge CLK);
        @(negedge CLK);
        RESETn = 1'b1;
        #1;
        check_reset_outputs("after_reset");
        m_active_en  = '1;
        m_pending_en = '1;
        m_pending    = 1'b0;
        m_acc        = '0;
        exp_cmask    = '0;
        exp_cvalid   = 1'b0;
        exp_q.delete();
        exp_q.push_back(25'd0);
    endtask

    // One pixel clock: drive inputs, advance the model, then compare the output that is due now.
    task automatic cycle(input logic pv, input logic fs, input logic [N-1:0] draw,
                         input logic [8*N-1:0] rgb, input logic [7:0] bg,
                         input logic cv, input logic [N-1:0] cen);
        logic [N-1:0] opq;
        logic [N-1:0] coll;
        logic [7:0]   pix;
        logic [24:0]  e;
        logic         ready;
        int           top;

        ready = !m_pending;
        check_eq("cfg_ready", bus.cfg_ready, ready);

        bus.pix_valid      = pv;
        bus.frame_start    = fs;
        bus.layer_draw     = draw;
        bus.layer_rgb      = rgb;
        bus.background_rgb = bg;
        bus.cfg_valid      = cv;
        bus.cfg_layer_en   = cen;

        top = -1;
        for (int i = 0; i < N; i++) begin
            opq[i] = draw[i] && m_active_en[i] && (rgb[8*i +: 8] != 8'hFF);
            if (opq[i]) top = i;
        end
        pix = (top < 0) ? bg : rgb[8*top +: 8];
        exp_q.push_back(expand(pv, pix));

        coll = (pv && $countones(opq) > 1) ? opq : '0;
`ifdef LAYER_COMPOSITOR_COLLISION_EN
        if (fs) begin
            exp_cmask  = m_acc;
            exp_cvalid = 1'b1;
            m_acc      = coll;
        end else begin
            exp_cvalid = 1'b0;
            m_acc      = m_acc | coll;
        end
`else
        exp_cmask  = '0;
        exp_cvalid = 1'b0;
        m_acc      = m_acc | coll;
`endif

        if (fs && m_pending) begin
            m_active_en = m_pending_en;
            m_pending   = 1'b0;
        end
        if (cv && ready) begin
            m_pending_en = cen;
            m_pending    = 1'b1;
        end

        @(posedge CLK);
        @(negedge CLK);
        e = exp_q.pop_front();
        check_eq("out_valid", bus.out_valid, e[24]);
        check_eq("r", bus.m_mVGA_R, e[23:16]);
        check_eq("g", bus.m_mVGA_G, e[15:8]);
        check_eq("b", bus.m_mVGA_B, e[7:0]);
        check_eq("cmask", bus.collision_mask, exp_cmask);
        check_eq("cvalid", bus.collision_valid, exp_cvalid);
    endtask

    task automatic pix(input logic fs, input logic [N-1:0] draw, input logic [8*N-1:0] rgb,
                       input logic [7:0] bg);
        cycle(1'b1, fs, draw, rgb, bg, 1'b0, '0);
    endtask

    initial begin
        logic [8*N-1:0] rgb;
        drive_idle();
        #2;
        apply_reset();

        // priority: layers 1 and 3 drawn, layer 3 wins
        pix(0, 4'b1010, {8'hE0, 8'h00, 8'h1C, 8'h00}, 8'h00);
        // transparency: only layer 3 with the key, background shows
        pix(0, 4'b1000, {8'hFF, 8'h00, 8'h00, 8'h00}, 8'h03);

        // enable handshake: hide layer 3 from the frame after the next frame_start
        cycle(1, 0, 4'b1000, {8'hE0, 24'h0}, 8'h03, 1'b1, 4'b0111);
        pix(0, 4'b1000, {8'hE0, 24'h0}, 8'h03);
        cycle(1, 0, 4'b1000, {8'hE0, 24'h0}, 8'h03, 1'b1, 4'b0001);
        pix(1, 4'b1000, {8'hE0, 24'h0}, 8'h03);
        pix(0, 4'b1000, {8'hE0, 24'h0}, 8'h03);
        pix(0, 4'b1001, {8'hE0, 16'h0, 8'h1C}, 8'h03);

        // transfer in the frame_start cycle is deferred one frame
        cycle(1, 1, 4'b1000, {8'hE0, 24'h0}, 8'h03, 1'b1, 4'b1111);
        pix(0, 4'b1000, {8'hE0, 24'h0}, 8'h03);
        pix(1, 4'b1000, {8'hE0, 24'h0}, 8'h03);
        pix(0, 4'b1000, {8'hE0, 24'h0}, 8'h03);

        // collision: layers 0 and 2 overlap once, then a clean frame
        pix(1, 4'b0000, '0, 8'h00);
        pix(0, 4'b0001, {24'h0, 8'h10}, 8'h00);
        pix(0, 4'b0101, {8'h00, 8'h44, 8'h00, 8'h10}, 8'h00);
        pix(0, 4'b0100, {8'h00, 8'h44, 16'h0}, 8'h00);
        pix(1, 4'b0000, '0, 8'h00);
        pix(0, 4'b0010, {16'h0, 8'h22, 8'h00}, 8'h00);
        pix(1, 4'b0000, '0, 8'h00);
        pix(1, 4'b0000, '0, 8'h00);

        // reset mid-frame with an update pending
        cycle(1, 0, 4'b1000, {8'hE0, 24'h0}, 8'h00, 1'b1, 4'b0000);
        pix(0, 4'b0101, {8'h00, 8'h44, 8'h00, 8'h10}, 8'h00);
        @(negedge CLK);
        apply_reset();
        pix(0, 4'b1000, {8'hE0, 24'h0}, 8'h00);
        pix(1, 4'b1000, {8'hE0, 24'h0}, 8'h00);
        pix(0, 4'b1000, {8'hE0, 24'h0}, 8'h00);

        // randomised frames with back-to-back frame_start and random enable updates
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++)
                rgb[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            cycle(1'($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 29) == 0),
                  N'($urandom), rgb, 8'($urandom),
                  1'($urandom_range(0, 5) == 0), N'($urandom));
        end

        cycle(0, 0, '0, '0, 8'h00, 0, '0);
        cycle(0, 1, '0, '0, 8'h00, 0, '0);
        cycle(0, 0, '0, '0, 8'h00, 0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end
endmodule
